// File: rtl/axi_read_router.sv
// Single-outstanding AXI read router: decodes ARADDR into one of three slaves or the
// default DECERR slave (port 3). Define AXI_RD_DECERR_CNT_EN to enable decerr_cnt.
module axi_read_router #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   ARID_M,
    input  logic [ADDR_W-1:0] ARADDR_M,
    input  logic [3:0]        ARLEN_M,
    input  logic [2:0]        ARSIZE_M,
    input  logic [1:0]        ARBURST_M,
    input  logic              ARVALID_M,
    output logic              ARREADY_M,
    output logic [ID_W-1:0]   RID_M,
    output logic [DATA_W-1:0] RDATA_M,
    output logic [1:0]        RRESP_M,
    output logic              RLAST_M,
    output logic              RVALID_M,
    input  logic              RREADY_M,
    output logic [ID_W-1:0]   ARID_S,
    output logic [ADDR_W-1:0] ARADDR_S,
    output logic [3:0]        ARLEN_S,
    output logic [2:0]        ARSIZE_S,
    output logic [1:0]        ARBURST_S,
    output logic [3:0]        ARVALID_S,
    input  logic [3:0]        ARREADY_S,
    input  logic [4*ID_W-1:0] RID_S,
    input  logic [4*DATA_W-1:0] RDATA_S,
    input  logic [7:0]        RRESP_S,
    input  logic [3:0]        RLAST_S,
    input  logic [3:0]        RVALID_S,
    output logic [3:0]        RREADY_S,
    output logic [15:0]       decerr_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] S0_HI = ADDR_W'(32'h0000_FFFF);
    localparam logic [ADDR_W-1:0] S1_LO = ADDR_W'(32'h0001_0000);
    localparam logic [ADDR_W-1:0] S1_HI = ADDR_W'(32'h0001_FFFF);
    localparam logic [ADDR_W-1:0] S2_LO = ADDR_W'(32'h2000_0000);
    localparam logic [ADDR_W-1:0] S2_HI = ADDR_W'(32'h201F_FFFF);

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [ID_W-1:0]   ar_id_q, ar_id_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [3:0]        ar_len_q, ar_len_d;
    logic [2:0]        ar_size_q, ar_size_d;
    logic [1:0]        ar_burst_q, ar_burst_d;
    logic [1:0]        sel_dec;
    logic              ar_hs;

    always_comb begin
        if (ARADDR_M <= S0_HI)
            sel_dec = 2'd0;
        else if (ARADDR_M >= S1_LO && ARADDR_M <= S1_HI)
            sel_dec = 2'd1;
        else if (ARADDR_M >= S2_LO && ARADDR_M <= S2_HI)
            sel_dec = 2'd2;
        else
            sel_dec = 2'd3;
    end

    assign ar_hs = (state_q == IDLE) && ARVALID_M;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        ARREADY_M  = 1'b0;
        ARVALID_S  = '0;
        RREADY_S   = '0;
        RVALID_M   = 1'b0;
        RID_M      = '0;
        RDATA_M    = '0;
        RRESP_M    = '0;
        RLAST_M    = 1'b0;
        case (state_q)
            IDLE: begin
                ARREADY_M = 1'b1;
                if (ar_hs) begin
                    sel_d      = sel_dec;
                    ar_id_d    = ARID_M;
                    ar_addr_d  = ARADDR_M;
                    ar_len_d   = ARLEN_M;
                    ar_size_d  = ARSIZE_M;
                    ar_burst_d = ARBURST_M;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                ARVALID_S[sel_q] = 1'b1;
                if (ARREADY_S[sel_q])
                    state_d = DATA;
            end
            DATA: begin
                // R path is purely combinational from the selected slave; burst end is its RLAST.
                RVALID_M        = RVALID_S[sel_q];
                RID_M           = RID_S[sel_q*ID_W +: ID_W];
                RDATA_M         = RDATA_S[sel_q*DATA_W +: DATA_W];
                RRESP_M         = RRESP_S[sel_q*2 +: 2];
                RLAST_M         = RLAST_S[sel_q];
                RREADY_S[sel_q] = RREADY_M;
                if (RVALID_S[sel_q] && RREADY_M && RLAST_S[sel_q])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
        end
    end

    assign ARID_S    = ar_id_q;
    assign ARADDR_S  = ar_addr_q;
    assign ARLEN_S   = ar_len_q;
    assign ARSIZE_S  = ar_size_q;
    assign ARBURST_S = ar_burst_q;

`ifdef AXI_RD_DECERR_CNT_EN
    logic [15:0] decerr_q, decerr_d;

    always_comb begin
        decerr_d = decerr_q;
        if (ar_hs && sel_dec == 2'd3 && decerr_q != 16'hFFFF)
            decerr_d = decerr_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            decerr_q <= '0;
        else
            decerr_q <= decerr_d;
    end

    assign decerr_cnt = decerr_q;
`else
    assign decerr_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_read_router.sv
// Directed bench for axi_read_router; inputs driven on the falling edge, outputs checked 1 time unit later.
module tb_axi_read_router;

`ifdef AXI_RD_DECERR_CNT_EN
    localparam logic [15:0] DEC_ONE = 16'd1;
`else
    localparam logic [15:0] DEC_ONE = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ARID_M;
    logic [31:0] ARADDR_M;
    logic [3:0]  ARLEN_M;
    logic [2:0]  ARSIZE_M;
    logic [1:0]  ARBURST_M;
    logic        ARVALID_M;
    logic        ARREADY_M;
    logic [7:0]  RID_M;
    logic [31:0] RDATA_M;
    logic [1:0]  RRESP_M;
    logic        RLAST_M;
    logic        RVALID_M;
    logic        RREADY_M;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic [3:0]  ARVALID_S;
    logic [3:0]  ARREADY_S;
    logic [31:0] RID_S;
    logic [127:0] RDATA_S;
    logic [7:0]  RRESP_S;
    logic [3:0]  RLAST_S;
    logic [3:0]  RVALID_S;
    logic [3:0]  RREADY_S;
    logic [15:0] decerr_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_read_router #(.ID_W(8), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
        .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .decerr_cnt(decerr_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_r(input int n, input logic v, input logic [7:0] id,
                         input logic [31:0] d, input logic [1:0] resp, input logic last);
        RVALID_S[n]       = v;
        RID_S[n*8 +: 8]   = id;
        RDATA_S[n*32 +: 32] = d;
        RRESP_S[n*2 +: 2] = resp;
        RLAST_S[n]        = last;
    endtask

    task automatic clr_s();
        ARREADY_S = '0;
        RID_S     = '0;
        RDATA_S   = '0;
        RRESP_S   = '0;
        RLAST_S   = '0;
        RVALID_S  = '0;
    endtask

    // Presents one AR for a single cycle; returns at the falling edge of the first ADDR cycle.
    task automatic ar_start(input string tag, input logic [7:0] id, input logic [31:0] addr,
                            input logic [3:0] len);
        @(negedge clk);
        ARID_M = id; ARADDR_M = addr; ARLEN_M = len; ARSIZE_M = 3'd2; ARBURST_M = 2'b01;
        ARVALID_M = 1'b1;
        #1 check({tag, "_arready"}, ARREADY_M, 1);
        @(negedge clk);
        ARVALID_M = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int b;
        rst = 1'b0;
        ARID_M = '0; ARADDR_M = '0; ARLEN_M = '0; ARSIZE_M = '0; ARBURST_M = '0;
        ARVALID_M = 1'b0; RREADY_M = 1'b0;
        clr_s();

        // reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_arready", ARREADY_M, 1);
        check("rst_arvalid", ARVALID_S, 0);
        check("rst_rready", RREADY_S, 0);
        check("rst_rvalid", RVALID_M, 0);
        check("rst_araddr", ARADDR_S, 0);
        check("rst_rdata", RDATA_M, 0);
        check("rst_decerr", decerr_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        // T1: slave 0 single beat, ARREADY after 2 cycles
        ar_start("t1", 8'h03, 32'h0000_0010, 4'd0);
        #1;
        check("t1_arvalid_c1", ARVALID_S, 4'b0001);
        check("t1_araddr", ARADDR_S, 32'h0000_0010);
        check("t1_arid", ARID_S, 8'h03);
        check("t1_arready_busy", ARREADY_M, 0);
        @(negedge clk);
        ARREADY_S = 4'b0001;
        #1 check("t1_arvalid_c2", ARVALID_S, 4'b0001);
        @(negedge clk);
        ARREADY_S = '0;
        set_r(0, 1'b1, 8'h03, 32'hDEAD_BEEF, 2'b00, 1'b1);
        RREADY_M = 1'b1;
        #1;
        check("t1_arvalid_drop", ARVALID_S, 4'b0000);
        check("t1_rvalid", RVALID_M, 1);
        check("t1_rdata", RDATA_M, 32'hDEAD_BEEF);
        check("t1_rresp", RRESP_M, 2'b00);
        check("t1_rlast", RLAST_M, 1);
        check("t1_rid", RID_M, 8'h03);
        check("t1_rready_s", RREADY_S, 4'b0001);
        @(negedge clk);
        clr_s();
        RREADY_M = 1'b0;
        #1;
        check("t1_idle", ARREADY_M, 1);
        check("t1_rvalid_idle", RVALID_M, 0);

        // T2: slave 2 four beats with RREADY_M toggling
        ar_start("t2", 8'h22, 32'h2000_0100, 4'd3);
        ARREADY_S = 4'b0100;
        #1 check("t2_arvalid", ARVALID_S, 4'b0100);
        b = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            ARREADY_S = '0;
            RREADY_M = c[0];
            set_r(2, 1'b1, 8'h22, 32'hA0 + b, 2'b00, b == 3);
            #1;
            check("t2_rdata", RDATA_M, 32'hA0 + b);
            check("t2_rlast", RLAST_M, b == 3);
            check("t2_rready_s", RREADY_S, {1'b0, RREADY_M, 2'b00});
            check("t2_busy", ARREADY_M, 0);
            if (RREADY_M) b++;
        end
        @(negedge clk);
        clr_s();
        RREADY_M = 1'b0;
        #1 check("t2_idle", ARREADY_M, 1);

        // T3: unmapped address to default slave
        ar_start("t3", 8'h15, 32'h3000_0000, 4'd0);
        ARREADY_S = 4'b1000;
        #1 check("t3_arvalid", ARVALID_S, 4'b1000);
        @(negedge clk);
        ARREADY_S = '0;
        set_r(3, 1'b1, 8'h15, 32'h0, 2'b11, 1'b1);
        RREADY_M = 1'b1;
        #1;
        check("t3_rid", RID_M, 8'h15);
        check("t3_rresp", RRESP_M, 2'b11);
        check("t3_rlast", RLAST_M, 1);
        check("t3_rready_s", RREADY_S, 4'b1000);
        @(negedge clk);
        clr_s();
        RREADY_M = 1'b0;
        #1 check("t3_decerr", decerr_cnt, DEC_ONE);

        // T4: back-to-back reads, ARVALID_M held
        @(negedge clk);
        ARID_M = 8'h01; ARADDR_M = 32'h0001_0000; ARLEN_M = 4'd0; ARVALID_M = 1'b1;
        #1 check("t4_arready1", ARREADY_M, 1);
        @(negedge clk);
        ARID_M = 8'h02; ARADDR_M = 32'h0000_0000;
        ARREADY_S = 4'b0010;
        #1;
        check("t4_arvalid1", ARVALID_S, 4'b0010);
        check("t4_hold_busy", ARREADY_M, 0);
        @(negedge clk);
        ARREADY_S = '0;
        set_r(1, 1'b1, 8'h01, 32'h1111, 2'b00, 1'b1);
        RREADY_M = 1'b1;
        #1;
        check("t4_rdata1", RDATA_M, 32'h1111);
        check("t4_data_busy", ARREADY_M, 0);
        @(negedge clk);
        clr_s();
        #1 check("t4_arready2", ARREADY_M, 1);
        @(negedge clk);
        ARVALID_M = 1'b0;
        #1;
        check("t4_arvalid2", ARVALID_S, 4'b0001);
        check("t4_arid2", ARID_S, 8'h02);
        check("t4_araddr2", ARADDR_S, 32'h0);
        ARREADY_S = 4'b0001;
        @(negedge clk);
        ARREADY_S = '0;
        set_r(0, 1'b1, 8'h02, 32'h2222, 2'b00, 1'b1);
        #1;
        check("t4_rdata2", RDATA_M, 32'h2222);
        check("t4_rready_s2", RREADY_S, 4'b0001);
        @(negedge clk);
        clr_s();
        RREADY_M = 1'b0;

        // T5: stale RVALID in IDLE, then spurious slave-1 RVALID during a slave-0 burst
        @(negedge clk);
        set_r(2, 1'b1, 8'h99, 32'h5555, 2'b00, 1'b1);
        ARID_M = 8'h05; ARADDR_M = 32'h0000_0040; ARLEN_M = 4'd0; ARVALID_M = 1'b1;
        RREADY_M = 1'b1;
        #1;
        check("t5_idle_arready", ARREADY_M, 1);
        check("t5_idle_rvalid", RVALID_M, 0);
        check("t5_idle_rready_s", RREADY_S, 0);
        @(negedge clk);
        ARVALID_M = 1'b0;
        #1;
        check("t5_arvalid", ARVALID_S, 4'b0001);
        check("t5_addr_rvalid", RVALID_M, 0);
        ARREADY_S = 4'b0001;
        @(negedge clk);
        ARREADY_S = '0;
        set_r(2, 1'b0, 8'h0, 32'h0, 2'b00, 1'b0);
        set_r(1, 1'b1, 8'h09, 32'hBAD1, 2'b00, 1'b1);
        #1;
        check("t5_spur_rvalid", RVALID_M, 0);
        check("t5_spur_rready_s", RREADY_S, 4'b0001);
        @(negedge clk);
        set_r(0, 1'b1, 8'h05, 32'h600D, 2'b00, 1'b1);
        #1;
        check("t5_rvalid", RVALID_M, 1);
        check("t5_rdata", RDATA_M, 32'h600D);
        check("t5_rready_s", RREADY_S, 4'b0001);
        @(negedge clk);
        clr_s();
        RREADY_M = 1'b0;
        #1 check("t5_idle", ARREADY_M, 1);

        // T6: reset during beat 2 of a 4-beat burst, then a clean read
        ar_start("t6", 8'h07, 32'h0000_0000, 4'd3);
        ARREADY_S = 4'b0001;
        @(negedge clk);
        ARREADY_S = '0;
        set_r(0, 1'b1, 8'h07, 32'hC0, 2'b00, 1'b0);
        RREADY_M = 1'b1;
        #1 check("t6_beat1", RDATA_M, 32'hC0);
        @(negedge clk);
        set_r(0, 1'b1, 8'h07, 32'hC1, 2'b00, 1'b0);
        #1 check("t6_beat2", RDATA_M, 32'hC1);
        rst = 1'b0;
        #1;
        check("t6_rst_arready", ARREADY_M, 1);
        check("t6_rst_rvalid", RVALID_M, 0);
        check("t6_rst_rready_s", RREADY_S, 0);
        check("t6_rst_arvalid", ARVALID_S, 0);
        check("t6_rst_araddr", ARADDR_S, 0);
        check("t6_rst_arid", ARID_S, 0);
        check("t6_rst_rdata", RDATA_M, 0);
        check("t6_rst_decerr", decerr_cnt, 0);
        clr_s();
        RREADY_M = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ar_start("t6b", 8'h08, 32'h0000_0000, 4'd0);
        ARREADY_S = 4'b0001;
        #1 check("t6b_arvalid", ARVALID_S, 4'b0001);
        @(negedge clk);
        ARREADY_S = '0;
        set_r(0, 1'b1, 8'h08, 32'h7777, 2'b00, 1'b1);
        RREADY_M = 1'b1;
        #1;
        check("t6b_rdata", RDATA_M, 32'h7777);
        check("t6b_rid", RID_M, 8'h08);
        @(negedge clk);
        clr_s();
        RREADY_M = 1'b0;
        #1 check("t6b_idle", ARREADY_M, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
